// File: rtl/simmem_pkg.sv
// Shared types and widths for the simulated-memory write path.
// Holds the AXI-like channel structs and the write-response FSM encoding.
package simmem_pkg;

  localparam int unsigned IdWidth     = 8;
  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned AxLenWidth  = 8;
  localparam int unsigned AxSizeWidth = 3;
  localparam int unsigned DataWidth   = 64;
  localparam int unsigned RespWidth   = 2;
  localparam int unsigned UserWidth   = 1;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic [AxLenWidth-1:0]  burst_length;
    logic [AxSizeWidth-1:0] burst_size;
  } write_addr_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [DataWidth-1:0]     data;
    logic [DataWidth/8-1:0]   strb;
    logic                     last;
  } write_data_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [RespWidth-1:0] response;
    logic [UserWidth-1:0] user_signal;
  } write_resp_t;

  // Only the fields needed to close a burst are kept per buffered address.
  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [AxLenWidth-1:0] burst_length;
  } aw_entry_t;

  localparam int unsigned AwEntryWidth = IdWidth + AxLenWidth;

  typedef enum logic {
    DATA = 1'b0,
    RESP = 1'b1
  } wresp_state_e;

endpackage

// File: rtl/simmem_wresp_fifo.sv
// In-order FIFO of buffered write-address entries.
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module simmem_wresp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_i) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !push_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/simmem_wresp_responder.sv
// Write-response generator: buffers AW entries, counts W beats and issues one B per burst.
// Define SIMMEM_WRESP_CHECK_EN to flag last/id protocol violations with response = 1.
module simmem_wresp_responder
  import simmem_pkg::*;
#(
  parameter int unsigned AwFifoDepth = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  write_addr_req_t waddr_req_i,
  input  logic            waddr_valid_i,
  output logic            waddr_ready_o,
  input  write_data_req_t wdata_req_i,
  input  logic            wdata_valid_i,
  output logic            wdata_ready_o,
  output write_resp_t     wresp_o,
  output logic            wresp_valid_o,
  input  logic            wresp_ready_i
);

  wresp_state_e          state_q, state_d;
  logic [AxLenWidth-1:0] beat_cnt_q, beat_cnt_d;
  write_resp_t           resp_q, resp_d;
  logic                  fifo_full, fifo_empty;
  logic [AwEntryWidth-1:0] fifo_rdata;
  aw_entry_t             head, push_entry;
  logic                  aw_hs, w_hs, b_hs, final_beat, burst_err;
  logic                  unused_fields;

  assign unused_fields = ^{waddr_req_i.addr, waddr_req_i.burst_size, wdata_req_i};

  assign push_entry = '{id: waddr_req_i.id, burst_length: waddr_req_i.burst_length};
  assign head       = aw_entry_t'(fifo_rdata);

  assign waddr_ready_o = !fifo_full;
  assign aw_hs         = waddr_valid_i && waddr_ready_o;
  assign w_hs          = wdata_valid_i && wdata_ready_o;
  assign b_hs          = wresp_valid_o && wresp_ready_i;
  assign final_beat    = w_hs && (beat_cnt_q == head.burst_length);

  simmem_wresp_fifo #(
    .Depth (AwFifoDepth),
    .Width (AwEntryWidth)
  ) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs),
    .data_i  (push_entry),
    .pop_i   (final_beat),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SIMMEM_WRESP_CHECK_EN
  logic err_q, err_d, beat_err;

  assign beat_err  = w_hs && ((wdata_req_i.last != (beat_cnt_q == head.burst_length)) ||
                              (wdata_req_i.id != head.id));
  assign burst_err = err_q || beat_err;

  always_comb begin
    err_d = burst_err;
    if (final_beat) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign burst_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= DATA;
      beat_cnt_q <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      resp_q     <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DATA: if (final_beat) state_d = RESP;
      RESP: if (b_hs)       state_d = DATA;
      default:              state_d = DATA;
    endcase
  end

  always_comb begin
    wdata_ready_o = (state_q == DATA) && !fifo_empty;
    wresp_valid_o = (state_q == RESP);
    wresp_o       = resp_q;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    resp_d     = resp_q;
    if (final_beat) begin
      beat_cnt_d           = '0;
      resp_d.id            = head.id;
      resp_d.response      = {{(RespWidth-1){1'b0}}, burst_err};
      resp_d.user_signal   = '0;
    end else if (w_hs) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
    // The response register is zero whenever no B is outstanding.
    if (b_hs) begin
      resp_d = '0;
    end
  end

endmodule

// File: tb/tb_simmem_wresp_responder.sv
// Randomized and directed bench for simmem_wresp_responder against a queue-based burst model.
// Expected B response follows SIMMEM_WRESP_CHECK_EN when the bench is built with it.
module tb_simmem_wresp_responder;
  import simmem_pkg::*;

  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  write_addr_req_t waddr_req_i = '0;
  logic            waddr_valid_i = 1'b0;
  logic            waddr_ready_o;
  write_data_req_t wdata_req_i = '0;
  logic            wdata_valid_i = 1'b0;
  logic            wdata_ready_o;
  write_resp_t     wresp_o;
  logic            wresp_valid_o;
  logic            wresp_ready_i = 1'b0;

  simmem_wresp_responder #(.AwFifoDepth(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .waddr_req_i   (waddr_req_i),
    .waddr_valid_i (waddr_valid_i),
    .waddr_ready_o (waddr_ready_o),
    .wdata_req_i   (wdata_req_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .wresp_o       (wresp_o),
    .wresp_valid_o (wresp_valid_o),
    .wresp_ready_i (wresp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending bursts in arrival order, beats seen on the head,
  // and at most one outstanding B.
  typedef struct { logic [7:0] id; int len; } burst_t;
  burst_t     mq[$];
  int         m_beats = 0;
  bit         m_err = 0;
  bit         m_bpend = 0;
  logic [7:0] m_bid = '0;
  logic [1:0] m_bresp = '0;
  logic [7:0] b_seen[$];

  function automatic void model_reset();
    mq.delete();
    m_beats = 0; m_err = 0; m_bpend = 0; m_bid = '0; m_bresp = '0;
  endfunction

  task automatic check_outputs(input string ctx);
    write_resp_t exp_b;
    exp_b = '0;
    if (m_bpend) begin
      exp_b.id = m_bid;
      exp_b.response = m_bresp;
    end
    check_eq({ctx, ".awready"}, waddr_ready_o, (mq.size() < DEPTH));
    check_eq({ctx, ".wready"},  wdata_ready_o, (!m_bpend && mq.size() > 0));
    check_eq({ctx, ".bvalid"},  wresp_valid_o, m_bpend);
    check_eq({ctx, ".bpayload"}, wresp_o, exp_b);
  endtask

  // Called at a falling edge: check, drive one cycle of inputs, advance the model.
  task automatic step(input logic awv, input logic [7:0] awid, input logic [7:0] awlen,
                      input logic wv, input logic wlast, input logic [7:0] wid,
                      input logic brdy);
    bit aw_hs, w_hs, b_hs, bad;
    burst_t nb;
    check_outputs("cyc");
    waddr_valid_i            = awv;
    waddr_req_i.id           = awid;
    waddr_req_i.burst_length = awlen;
    waddr_req_i.addr         = $urandom;
    waddr_req_i.burst_size   = 3'($urandom_range(0, 3));
    wdata_valid_i            = wv;
    wdata_req_i.last         = wlast;
    wdata_req_i.id           = wid;
    wdata_req_i.data         = {$urandom, $urandom};
    wdata_req_i.strb         = 8'hff;
    wresp_ready_i            = brdy;

    aw_hs = awv && (mq.size() < DEPTH);
    w_hs  = wv && !m_bpend && (mq.size() > 0);
    b_hs  = brdy && m_bpend;
    if (b_hs) begin
      b_seen.push_back(wresp_o.id);
      m_bpend = 0;
    end
    if (w_hs) begin
      bad = (wlast != (m_beats == mq[0].len)) || (wid != mq[0].id);
      m_err = m_err || bad;
      if (m_beats == mq[0].len) begin
        m_bpend = 1;
        m_bid   = mq[0].id;
`ifdef SIMMEM_WRESP_CHECK_EN
        m_bresp = m_err ? 2'd1 : 2'd0;
`else
        m_bresp = 2'd0;
`endif
        m_err   = 0;
        m_beats = 0;
        void'(mq.pop_front());
      end else begin
        m_beats++;
      end
    end
    if (aw_hs) begin
      nb.id  = awid;
      nb.len = int'(awlen);
      mq.push_back(nb);
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input logic brdy);
    step(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 8'h0, brdy);
  endtask

  // One well-formed W beat for the current head (or a stray beat if none).
  task automatic beat(input logic brdy);
    logic       l;
    logic [7:0] i;
    l = (mq.size() > 0) && (m_beats == mq[0].len);
    i = (mq.size() > 0) ? mq[0].id : 8'h0;
    step(1'b0, 8'h0, 8'h0, 1'b1, l, i, brdy);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() > 0 || m_bpend) && n < 600) begin
      beat(1'b1);
      n++;
    end
    check_eq("drain_done", (mq.size() == 0 && !m_bpend), 1'b1);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    waddr_valid_i = 1'b0;
    wdata_valid_i = 1'b0;
    wresp_ready_i = 1'b0;
    #1;
    check_eq("rst.awready", waddr_ready_o, 1'b1);
    check_eq("rst.wready",  wdata_ready_o, 1'b0);
    check_eq("rst.bvalid",  wresp_valid_o, 1'b0);
    check_eq("rst.bpayload", wresp_o, '0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int n;
    write_resp_t held;
    logic [7:0] hid;
    logic       hl;

    @(negedge clk_i);
    apply_reset();

    // Single-beat burst
    step(1'b1, 8'h12, 8'd0, 1'b0, 1'b0, 8'h0, 1'b0);
    step(1'b0, 8'h0, 8'h0, 1'b1, 1'b1, 8'h12, 1'b0);
    check_eq("len0.bvalid", wresp_valid_o, 1'b1);
    check_eq("len0.bid", wresp_o.id, 8'h12);
    check_eq("len0.bresp", wresp_o.response, 2'd0);
    idle(1'b1);

    // Two bursts complete in order
    b_seen.delete();
    step(1'b1, 8'h05, 8'd3, 1'b0, 1'b0, 8'h0, 1'b1);
    step(1'b1, 8'h09, 8'd1, 1'b0, 1'b0, 8'h0, 1'b1);
    drain();
    check_eq("order.count", b_seen.size(), 2);
    if (b_seen.size() == 2) begin
      check_eq("order.first", b_seen[0], 8'h05);
      check_eq("order.second", b_seen[1], 8'h09);
    end

    // FIFO full, then a pop frees exactly one slot a cycle later
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 8'd0, 1'b0, 1'b0, 8'h0, 1'b0);
    check_eq("full.awready", waddr_ready_o, 1'b0);
    step(1'b1, 8'h55, 8'd0, 1'b0, 1'b0, 8'h0, 1'b0);
    step(1'b1, 8'h55, 8'd0, 1'b1, 1'b1, 8'h01, 1'b0);
    check_eq("full.after_pop_awready", waddr_ready_o, 1'b1);
    step(1'b1, 8'h55, 8'd0, 1'b0, 1'b0, 8'h0, 1'b1);
    check_eq("full.fifth_taken", mq.size(), 4);
    drain();

    // Back-pressured B stays stable and blocks W
    step(1'b1, 8'h21, 8'd0, 1'b0, 1'b0, 8'h0, 1'b0);
    step(1'b1, 8'h22, 8'd0, 1'b1, 1'b1, 8'h21, 1'b0);
    held = wresp_o;
    check_eq("bp.held_id", held.id, 8'h21);
    for (int k = 0; k < 10; k++) begin
      check_eq("bp.stable", wresp_o, held);
      check_eq("bp.wready_low", wdata_ready_o, 1'b0);
      step(1'b0, 8'h0, 8'h0, 1'b1, 1'b1, 8'h22, 1'b0);
    end
    idle(1'b1);
    step(1'b0, 8'h0, 8'h0, 1'b1, 1'b1, 8'h22, 1'b0);
    check_eq("bp.resume_id", wresp_o.id, 8'h22);
    idle(1'b1);

    // Early last on beat 1 of a 3-beat burst
    step(1'b1, 8'h3c, 8'd2, 1'b0, 1'b0, 8'h0, 1'b0);
    step(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, 8'h3c, 1'b0);
    step(1'b0, 8'h0, 8'h0, 1'b1, 1'b1, 8'h3c, 1'b0);
    step(1'b0, 8'h0, 8'h0, 1'b1, 1'b1, 8'h3c, 1'b0);
`ifdef SIMMEM_WRESP_CHECK_EN
    check_eq("proto.bresp", wresp_o.response, 2'd1);
`else
    check_eq("proto.bresp", wresp_o.response, 2'd0);
`endif
    idle(1'b1);

    // Longest burst: 256 beats, no counter overflow
    step(1'b1, 8'h7e, 8'd255, 1'b0, 1'b0, 8'h0, 1'b0);
    n = 0;
    while (!wresp_valid_o && n < 400) begin
      beat(1'b0);
      n++;
    end
    check_eq("len255.beats", n, 256);
    check_eq("len255.bid", wresp_o.id, 8'h7e);
    idle(1'b1);

    // Reset in the middle of a burst drops it silently
    step(1'b1, 8'h33, 8'd3, 1'b0, 1'b0, 8'h0, 1'b0);
    beat(1'b0);
    beat(1'b0);
    apply_reset();
    b_seen.delete();
    for (int k = 0; k < 6; k++) idle(1'b1);
    check_eq("midrst.no_b", b_seen.size(), 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      hid = (mq.size() > 0) ? mq[0].id : 8'h0;
      hl  = (mq.size() > 0) && (m_beats == mq[0].len);
      if ($urandom_range(0, 15) == 0) hl = ~hl;
      if ($urandom_range(0, 15) == 0) hid = 8'($urandom_range(0, 3));
      step(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 3)),
           ($urandom_range(0, 63) == 0) ? 8'd255 : 8'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), hl, hid, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/simmem_wresp_responder.md
SIMMEM_WRESP_RESPONDER -- requirements
Module: simmem_wresp_responder

Interface
REQ-001 SHALL have parameter AwFifoDepth, default 4, meaning the number of write-address entries buffered (power of two, at least 2).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port waddr_req_i, input, write_addr_req_t: the write-address request.
REQ-005 SHALL have port waddr_valid_i, input, 1 bit: the write-address request is valid.
REQ-006 SHALL have port waddr_ready_o, output, 1 bit: a write address can be accepted.
REQ-007 SHALL have port wdata_req_i, input, write_data_req_t: the write-data beat.
REQ-008 SHALL have port wdata_valid_i, input, 1 bit: the write-data beat is valid.
REQ-009 SHALL have port wdata_ready_o, output, 1 bit: a write-data beat can be accepted.
REQ-010 SHALL have port wresp_o, output, write_resp_t: the write response.
REQ-011 SHALL have port wresp_valid_o, output, 1 bit: the write response is valid.
REQ-012 SHALL have port wresp_ready_i, input, 1 bit: the write response is accepted downstream.

Function
REQ-013 SHALL treat a handshake as valid AND ready in the same cycle, on every channel.
REQ-014 SHALL push the id and burst_length of each accepted write address into an in-order FIFO.
REQ-015 SHALL drive waddr_ready_o = FIFO not full, as a registered function of FIFO state with no combinational path from a same-cycle pop.
REQ-016 SHALL use a two-state FSM: DATA and RESP.
REQ-017 SHALL drive wdata_ready_o = (state == DATA) AND FIFO not empty; an address pushed into an empty FIFO is usable from the following cycle (no bypass).
REQ-018 SHALL keep a beat counter of AxLenWidth bits, which increments on each W handshake in DATA.
REQ-019 SHALL treat a W handshake while beat counter == head burst_length as the final beat (burst_length + 1 beats in total): pop the FIFO, clear the counter, load the response register, and go to RESP.
REQ-020 SHALL assert wresp_valid_o exactly in RESP, starting the cycle after the final beat, with wresp_o.id = head id.
REQ-021 SHALL hold wresp_o stable while wresp_valid_o is high and wresp_ready_i is low.
REQ-022 SHALL, on a B handshake, return to DATA the next cycle, deassert wresp_valid_o, and clear wresp_o to 0.
REQ-023 SHALL, with the FIFO full and the final beat popping in the same cycle, refuse the AW that cycle; waddr_ready_o rises the next cycle.
REQ-024 SHALL allow an AW push in the same cycle as a pop or a W beat, with the FIFO count updated by both events.
REQ-025 SHALL require burst_length = 0 to complete on the first beat; burst_length = 255 SHALL not overflow the counter.
REQ-026 SHALL set wresp_o.response = 0 (OKAY) unless REQ-032 applies; user_signal = 0.

Reset
REQ-027 SHALL, while rst_ni is low, immediately force: FIFO empty, counter = 0, state = DATA, wresp_valid_o = 0, wresp_o = 0.
REQ-028 SHALL hold waddr_ready_o = 1 and wdata_ready_o = 0 during and after reset.
REQ-029 SHALL discard any burst in flight if reset asserts mid-burst, without emitting a response.

Configuration
REQ-030 SHALL have the macro SIMMEM_WRESP_CHECK_EN select the protocol check.
REQ-031 SHALL, without SIMMEM_WRESP_CHECK_EN, ignore wdata_req_i.last and wdata_req_i.id; response is always 0.
REQ-032 SHALL, with SIMMEM_WRESP_CHECK_EN, keep a sticky error bit per burst. The bit is set when any beat's last flag differs from (counter == burst_length), or when its id differs from the head id. The B response of that burst carries response = 1, and the bit clears on pop.

Structure
REQ-033 SHALL place write_addr_req_t, write_data_req_t, write_resp_t, the widths, and a new wresp_state_e enum (DATA, RESP) in simmem_pkg.
REQ-034 SHALL implement the FIFO as sub-module simmem_wresp_fifo (parameters Depth and entry width; push/pop/full/empty).

Verification
REQ-035 SHALL cover: AW id=0x12, len=0, then one W beat with last=1 -> wresp_valid_o high the next cycle, wresp_o.id=0x12, response=0.
REQ-036 SHALL cover: AW id=0x05 len=3 and AW id=0x09 len=1, then 6 W beats -> B id=0x05 after the 4th beat and B id=0x09 after the 6th, in order.
REQ-037 SHALL cover: 4 AWs with no W beats (Depth=4) -> waddr_ready_o=0 while a 5th AW is held; after the first burst completes, the 5th AW is accepted.
REQ-038 SHALL cover: wresp_ready_i held low 10 cycles -> wresp_o stable, wdata_ready_o=0 throughout, and the next burst resumes after the handshake.
REQ-039 SHALL cover: with SIMMEM_WRESP_CHECK_EN, AW len=2 and last=1 on beat 1 -> B response=1; without the macro -> response=0.
REQ-040 SHALL cover: rst_ni pulsed low mid-burst (2 of 4 beats done) -> all outputs at reset values and no B issued.
